// File: rtl/ad7616_conv_sequencer_if.sv
// rtl/ad7616_conv_sequencer_if.sv - AD7616 parallel bus signal bundle (CNVST/BUSY/CS/RD/WR/DB)
interface ad7616_conv_sequencer_if;
    logic        cnvst;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] db_i;
    logic [15:0] db_o;
    logic        db_t;
    logic        busy;

    modport master (
        output cnvst, cs_n, rd_n, wr_n, db_o, db_t,
        input  db_i, busy
    );

    modport slave (
        input  cnvst, cs_n, rd_n, wr_n, db_o, db_t,
        output db_i, busy
    );
endinterface

// File: rtl/ad7616_conv_sequencer.sv
// rtl/ad7616_conv_sequencer.sv - AD7616 conversion/readout sequencer with register access arbitration; optional AD7616_SEQ_BUSY_TIMEOUT_EN
module ad7616_conv_sequencer #(
    parameter int CNVST_WIDTH  = 2,
    parameter int STROBE_LOW   = 3,
    parameter int STROBE_HIGH  = 2,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cnvst_en,
    input  logic [31:0]                    conv_rate,
    input  logic [4:0]                     burst_length,
    ad7616_conv_sequencer_if.master        bus,
    output logic [15:0]                    adc_data,
    output logic                           adc_valid,
    output logic                           adc_sync,
    input  logic                           reg_req,
    input  logic                           reg_wr,
    input  logic [15:0]                    reg_wdata,
    output logic [15:0]                    reg_rdata,
    output logic                           reg_ack,
    output logic                           conv_overrun,
    output logic                           busy_timeout
);

    // One phase counter serves every timed state, so size it for the longest one.
    localparam int MAX_AB  = (CNVST_WIDTH > STROBE_LOW) ? CNVST_WIDTH : STROBE_LOW;
    localparam int MAX_CD  = (STROBE_HIGH > BUSY_TIMEOUT) ? STROBE_HIGH : BUSY_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        IDLE, CNV, WAIT_BH, WAIT_BL, RD_LOW, RD_HIGH, REG_LOW, REG_HIGH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   phase;
    logic [4:0]         idx;
    logic [4:0]         burst_len_q;
    logic               reg_wr_q;
    logic [31:0]        rate_cnt;
    logic               conv_pending;
    logic               in_conv;
    logic               take_conv;

    assign in_conv   = (state != IDLE) && (state != REG_LOW) && (state != REG_HIGH);
    assign take_conv = (state == IDLE) && conv_pending;

`ifndef AD7616_SEQ_BUSY_TIMEOUT_EN
    assign busy_timeout = 1'b0;
`endif

    // Conversion period timer; a wrap either queues one conversion or flags an overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_cnt     <= '0;
            conv_pending <= 1'b0;
            conv_overrun <= 1'b0;
        end else begin
            conv_overrun <= 1'b0;
            if (!cnvst_en || conv_rate < 32'd2) begin
                rate_cnt     <= '0;
                conv_pending <= 1'b0;
            end else begin
                if (take_conv)
                    conv_pending <= 1'b0;
                // >= so that lowering conv_rate mid-period still wraps
                if (rate_cnt >= conv_rate - 32'd1) begin
                    rate_cnt <= '0;
                    if (conv_pending || in_conv)
                        conv_overrun <= 1'b1;
                    else
                        conv_pending <= 1'b1;
                end else begin
                    rate_cnt <= rate_cnt + 32'd1;
                end
            end
        end
    end

    // Bus sequencer: conversion bursts and single register accesses share the DB bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            idx         <= '0;
            burst_len_q <= '0;
            reg_wr_q    <= 1'b0;
            bus.cnvst   <= 1'b0;
            bus.cs_n    <= 1'b1;
            bus.rd_n    <= 1'b1;
            bus.wr_n    <= 1'b1;
            bus.db_o    <= '0;
            bus.db_t    <= 1'b1;
            adc_data    <= '0;
            adc_valid   <= 1'b0;
            adc_sync    <= 1'b0;
            reg_rdata   <= '0;
            reg_ack     <= 1'b0;
`ifdef AD7616_SEQ_BUSY_TIMEOUT_EN
            busy_timeout <= 1'b0;
`endif
        end else begin
            adc_valid <= 1'b0;
            adc_sync  <= 1'b0;
            reg_ack   <= 1'b0;
`ifdef AD7616_SEQ_BUSY_TIMEOUT_EN
            busy_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (conv_pending) begin
                        state       <= CNV;
                        bus.cnvst   <= 1'b1;
                        burst_len_q <= burst_length;
                    end else if (reg_req) begin
                        state    <= REG_LOW;
                        reg_wr_q <= reg_wr;
                        bus.cs_n <= 1'b0;
                        if (reg_wr) begin
                            bus.wr_n <= 1'b0;
                            bus.db_t <= 1'b0;
                            bus.db_o <= reg_wdata;
                        end else begin
                            bus.rd_n <= 1'b0;
                        end
                    end
                end
                CNV: begin
                    if (phase == CNT_W'(CNVST_WIDTH - 1)) begin
                        bus.cnvst <= 1'b0;
                        state     <= WAIT_BH;
                        phase     <= '0;
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
                end
                WAIT_BH: begin
                    if (bus.busy) begin
                        state <= WAIT_BL;
                        phase <= '0;
                    end
`ifdef AD7616_SEQ_BUSY_TIMEOUT_EN
                    else if (phase == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        busy_timeout <= 1'b1;
                        bus.cs_n     <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
`endif
                end
                WAIT_BL: begin
                    if (!bus.busy) begin
                        bus.cs_n <= 1'b0;
                        bus.rd_n <= 1'b0;
                        idx      <= '0;
                        phase    <= '0;
                        state    <= RD_LOW;
                    end
`ifdef AD7616_SEQ_BUSY_TIMEOUT_EN
                    else if (phase == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        busy_timeout <= 1'b1;
                        bus.cs_n     <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
`endif
                end
                RD_LOW: begin
                    if (phase == CNT_W'(STROBE_LOW - 1)) begin
                        adc_data  <= bus.db_i;
                        adc_valid <= 1'b1;
                        adc_sync  <= (idx == 5'd0);
                        bus.rd_n  <= 1'b1;
                        phase     <= '0;
                        state     <= RD_HIGH;
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
                end
                RD_HIGH: begin
                    if (phase == CNT_W'(STROBE_HIGH - 1)) begin
                        phase <= '0;
                        if (idx == burst_len_q) begin
                            bus.cs_n <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx      <= idx + 5'd1;
                            bus.rd_n <= 1'b0;
                            state    <= RD_LOW;
                        end
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
                end
                REG_LOW: begin
                    if (phase == CNT_W'(STROBE_LOW - 1)) begin
                        if (!reg_wr_q)
                            reg_rdata <= bus.db_i;
                        bus.rd_n <= 1'b1;
                        bus.wr_n <= 1'b1;
                        bus.cs_n <= 1'b1;
                        bus.db_t <= 1'b1;
                        reg_ack  <= 1'b1;
                        phase    <= '0;
                        state    <= REG_HIGH;
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
                end
                REG_HIGH: begin
                    if (phase == CNT_W'(STROBE_HIGH - 1)) begin
                        phase <= '0;
                        state <= IDLE;
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
